scal_cfg_writer: RTL and testbench

//  Write side of the scaler parameter-load interface. Drives scaledatain/scalechoice/scaleload/

---
 rtl/scal_cfg_writer.sv | 149 ++++++++++++++
 tb/tb_scal_cfg_writer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scal_cfg_writer.sv
// Scaler parameter-load writer: host-written shadow table streamed into scaltop with timed
// load strobes, optional start pulse, abort, and PN-change edge pulse.
module scal_cfg_writer #(
  parameter int unsigned NUM_REGS  = 21,
  parameter int unsigned LOAD_HIGH = 2,
  parameter int unsigned LOAD_GAP  = 2
) (
  input  logic        clk_sys,
  input  logic        scalerst,
  input  logic        host_we,
  input  logic [4:0]  host_addr,
  input  logic [15:0] host_data,
  input  logic        cmd_load,
  input  logic        cmd_abort,
  input  logic        auto_start,
  input  logic        pn_req,
  output logic [15:0] scaledatain,
  output logic [4:0]  scalechoice,
  output logic        scaleload,
  output logic        scalstart,
  output logic        pn_change,
  output logic        busy,
  output logic        done,
  output logic        wr_err
);

  localparam int unsigned CntMax = (LOAD_HIGH > LOAD_GAP) ? LOAD_HIGH : LOAD_GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] HighLast = CntW'(LOAD_HIGH - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(LOAD_GAP - 1);
  localparam logic [4:0]      IdxLast  = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StGap,
    StStart,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     table_q [32];

  logic [15:0] data_q;
  logic [4:0]  choice_q;
  logic        load_q, start_q, pn_change_q, busy_q, done_q, wr_err_q, pn_req_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_load && !cmd_abort) begin
          state_d = StSetup;
          idx_d   = '0;
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = '0;
      end
      StStrobe: begin
        if (cnt_q == HighLast) begin
          state_d = StGap;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          if (idx_q == IdxLast) begin
            state_d = auto_start ? StStart : StDone;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = StSetup;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStart: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort wins over every busy-state transition; a running strobe is cut short.
    if (cmd_abort && state_q != StIdle) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_sys or negedge scalerst) begin
    if (!scalerst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      choice_q    <= '0;
      load_q      <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      pn_req_q    <= 1'b0;
      pn_change_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      load_q      <= (state_d == StStrobe);
      start_q     <= (state_d == StStart);
      done_q      <= (state_d == StDone);
      busy_q      <= (state_d == StSetup) || (state_d == StStrobe) ||
                     (state_d == StGap) || (state_d == StStart);
      wr_err_q    <= host_we && (state_q != StIdle);
      pn_req_q    <= pn_req;
      pn_change_q <= pn_req && !pn_req_q;
      // Data/choice only move on SETUP entry, so they hold while the strobe is high and in IDLE.
      if (state_d == StSetup) begin
        choice_q <= idx_d;
        data_q   <= table_q[idx_d];
      end
    end
  end

  always_ff @(posedge clk_sys or negedge scalerst) begin
    if (!scalerst) begin
      for (int i = 0; i < 32; i++) begin
        table_q[i] <= '0;
      end
    end else if (host_we && state_q == StIdle) begin
      table_q[host_addr] <= host_data;
    end
  end

  assign scaledatain = data_q;
  assign scalechoice = choice_q;
  assign scaleload   = load_q;
  assign scalstart   = start_q;
  assign pn_change   = pn_change_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_scal_cfg_writer.sv
// Scoreboard bench for scal_cfg_writer: expected strobe entries are queued per load command
// and popped on each observed scaleload rising edge.
module tb_scal_cfg_writer;

  localparam int unsigned NumRegs  = 3;
  localparam int unsigned LoadHigh = 2;
  localparam int unsigned LoadGap  = 2;

  logic        clk_sys = 1'b0;
  logic        scalerst = 1'b0;
  logic        host_we = 1'b0;
  logic [4:0]  host_addr = '0;
  logic [15:0] host_data = '0;
  logic        cmd_load = 1'b0;
  logic        cmd_abort = 1'b0;
  logic        auto_start = 1'b0;
  logic        pn_req = 1'b0;
  logic [15:0] scaledatain;
  logic [4:0]  scalechoice;
  logic        scaleload, scalstart, pn_change, busy, done, wr_err;

  scal_cfg_writer #(
    .NUM_REGS (NumRegs),
    .LOAD_HIGH(LoadHigh),
    .LOAD_GAP (LoadGap)
  ) dut (
    .clk_sys    (clk_sys),
    .scalerst   (scalerst),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .cmd_load   (cmd_load),
    .cmd_abort  (cmd_abort),
    .auto_start (auto_start),
    .pn_req     (pn_req),
    .scaledatain(scaledatain),
    .scalechoice(scalechoice),
    .scaleload  (scaleload),
    .scalstart  (scalstart),
    .pn_change  (pn_change),
    .busy       (busy),
    .done       (done),
    .wr_err     (wr_err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [4:0]  ch;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] tbl [32];
  int          tests = 0;
  int          fails = 0;

  int   n_strobe, n_start, n_done, n_pn, n_err, n_busy;
  int   first_busy, first_sl, start_cyc, done_cyc, err_cyc;
  logic sl_after_abort, busy_after_abort;
  logic [4:0]  we_addr = '0;
  logic [15:0] we_data = '0;

  task automatic push_seq();
    for (int k = 0; k < int'(NumRegs); k++) begin
      sb.push_back(exp_t'({5'(k), tbl[k]}));
    end
  endtask

  task automatic write_tbl(input logic [4:0] addr, input logic [15:0] data);
    @(negedge clk_sys);
    host_we   = 1'b1;
    host_addr = addr;
    host_data = data;
    @(negedge clk_sys);
    host_we   = 1'b0;
    tbl[addr] = data;
  endtask

  // Steps 'cycles' negedges, observing outputs then driving the one-cycle pulses for index i.
  task automatic watch(input int cycles, input int load_at, input int load2_at,
                       input int abort_at, input int we_at, input int pn_at);
    logic        sl_prev;
    int          hi_len;
    logic [4:0]  ch_l;
    logic [15:0] d_l;
    exp_t        e;
    sl_prev = 1'b0; hi_len = 0; ch_l = '0; d_l = '0;
    n_strobe = 0; n_start = 0; n_done = 0; n_pn = 0; n_err = 0; n_busy = 0;
    first_busy = -1; first_sl = -1; start_cyc = -1; done_cyc = -1; err_cyc = -1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (busy === 1'b1) begin
        n_busy++;
        if (first_busy < 0) first_busy = i;
      end
      if (scaleload === 1'b1 && !sl_prev) begin
        n_strobe++;
        if (first_sl < 0) first_sl = i;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected: got choice=%0d data=%h, required no strobe",
                   scalechoice, scaledatain);
        end else begin
          e = sb.pop_front();
          if (scalechoice !== e.ch || scaledatain !== e.d) begin
            fails++;
            $display("FAIL strobe_entry: got choice=%0d data=%h, required choice=%0d data=%h",
                     scalechoice, scaledatain, e.ch, e.d);
          end
        end
        ch_l = scalechoice; d_l = scaledatain; hi_len = 1;
      end else if (scaleload === 1'b1) begin
        hi_len++;
        tests++;
        if (scalechoice !== ch_l || scaledatain !== d_l) begin
          fails++;
          $display("FAIL strobe_stable: got choice=%0d data=%h, required choice=%0d data=%h",
                   scalechoice, scaledatain, ch_l, d_l);
        end
      end else if (sl_prev && abort_at < 0) begin
        tests++;
        if (hi_len != int'(LoadHigh)) begin
          fails++;
          $display("FAIL strobe_len: got %0d cycles, required %0d", hi_len, LoadHigh);
        end
      end
      sl_prev = (scaleload === 1'b1);
      if (scalstart === 1'b1) begin n_start++; start_cyc = i; end
      if (done === 1'b1) begin n_done++; done_cyc = i; end
      if (pn_change === 1'b1) n_pn++;
      if (wr_err === 1'b1) begin n_err++; err_cyc = i; end
      if (i == abort_at + 1) begin
        sl_after_abort = scaleload; busy_after_abort = busy;
      end
      cmd_load  = (i == load_at) || (i == load2_at);
      cmd_abort = (i == abort_at);
      host_we   = (i == we_at);
      host_addr = we_addr;
      host_data = we_data;
      if (pn_at >= 0) begin
        if (i == pn_at || i == pn_at + 10) pn_req = 1'b1;
        else if (i == pn_at + 5) pn_req = 1'b0;
      end
    end
    cmd_load = 1'b0; cmd_abort = 1'b0; host_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    tests++;
    if ({scaledatain, scalechoice, scaleload, scalstart, pn_change, busy, done, wr_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got data=%h choice=%0d load=%b start=%b pn=%b busy=%b done=%b err=%b, required all 0",
               scaledatain, scalechoice, scaleload, scalstart, pn_change, busy, done, wr_err);
    end
    scalerst = 1'b1;
    watch(20, -1, -1, -1, -1, -1);
    tests++;
    if (n_strobe + n_busy + n_start + n_done + n_pn + n_err != 0) begin
      fails++;
      $display("FAIL reset_idle_activity: got strobes=%0d busy=%0d start=%0d done=%0d, required 0",
               n_strobe, n_busy, n_start, n_done);
    end
  endtask

  task automatic test_load_auto();
    write_tbl(5'd0, 16'h1234);
    write_tbl(5'd1, 16'hABCD);
    write_tbl(5'd2, 16'h0F0F);
    write_tbl(5'd3, 16'h5555);
    auto_start = 1'b1;
    push_seq();
    watch(25, 0, -1, -1, -1, -1);
    tests++;
    if (first_busy != 1 || first_sl != 2 || n_busy != 16) begin
      fails++;
      $display("FAIL auto_latency: got busy@%0d load@%0d busy_cycles=%0d, required 1 2 16",
               first_busy, first_sl, n_busy);
    end
    tests++;
    if (n_strobe != 3 || sb.size() != 0) begin
      fails++;
      $display("FAIL auto_strobes: got %0d strobes, %0d left, required 3 and 0", n_strobe, sb.size());
    end
    tests++;
    if (n_start != 1 || start_cyc != 16 || n_done != 1 || done_cyc != 17) begin
      fails++;
      $display("FAIL auto_start_done: got start %0d@%0d done %0d@%0d, required 1@16 1@17",
               n_start, start_cyc, n_done, done_cyc);
    end
    tests++;
    if (busy !== 1'b0 || scalechoice !== 5'd2 || scaledatain !== 16'h0F0F) begin
      fails++;
      $display("FAIL auto_idle_hold: got busy=%b choice=%0d data=%h, required 0 2 0f0f",
               busy, scalechoice, scaledatain);
    end
  endtask

  task automatic test_load_noauto();
    auto_start = 1'b0;
    push_seq();
    watch(25, 0, -1, -1, -1, -1);
    tests++;
    if (n_strobe != 3 || n_start != 0 || n_done != 1 || done_cyc != 16 || busy !== 1'b0) begin
      fails++;
      $display("FAIL noauto: got strobes=%0d start=%0d done=%0d@%0d busy=%b, required 3 0 1@16 0",
               n_strobe, n_start, n_done, done_cyc, busy);
    end
  endtask

  task automatic test_abort();
    auto_start = 1'b1;
    push_seq();
    watch(30, 0, -1, 7, -1, -1);
    tests++;
    if (sl_after_abort !== 1'b0 || busy_after_abort !== 1'b0) begin
      fails++;
      $display("FAIL abort_response: got load=%b busy=%b, required 0 0",
               sl_after_abort, busy_after_abort);
    end
    tests++;
    if (n_strobe != 2 || n_start != 0 || n_done != 0 || sb.size() != 1) begin
      fails++;
      $display("FAIL abort_truncate: got strobes=%0d start=%0d done=%0d left=%0d, required 2 0 0 1",
               n_strobe, n_start, n_done, sb.size());
    end
    sb.delete();
    push_seq();
    watch(25, 0, -1, -1, -1, -1);
    tests++;
    if (n_strobe != 3 || n_done != 1 || sb.size() != 0) begin
      fails++;
      $display("FAIL abort_restart: got strobes=%0d done=%0d left=%0d, required 3 1 0",
               n_strobe, n_done, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    auto_start = 1'b1;
    we_addr = 5'd0;
    we_data = 16'hDEAD;
    push_seq();
    watch(30, 0, 6, -1, 3, -1);
    tests++;
    if (n_err != 1 || err_cyc != 4) begin
      fails++;
      $display("FAIL busy_wr_err: got %0d pulses@%0d, required 1@4", n_err, err_cyc);
    end
    tests++;
    if (n_strobe != 3 || n_done != 1 || done_cyc != 17) begin
      fails++;
      $display("FAIL busy_load_ignored: got strobes=%0d done=%0d@%0d, required 3 1@17",
               n_strobe, n_done, done_cyc);
    end
    push_seq();
    watch(25, 0, -1, -1, -1, -1);
    tests++;
    if (n_strobe != 3 || sb.size() != 0) begin
      fails++;
      $display("FAIL busy_table_rerun: got strobes=%0d left=%0d, required 3 0", n_strobe, sb.size());
    end
  endtask

  task automatic test_pn_change();
    push_seq();
    watch(30, 0, -1, -1, -1, 3);
    tests++;
    if (n_pn != 2 || n_strobe != 3) begin
      fails++;
      $display("FAIL pn_pulses: got %0d pulses %0d strobes, required 2 3", n_pn, n_strobe);
    end
    pn_req = 1'b0;
    watch(5, -1, -1, -1, -1, -1);
    tests++;
    if (n_pn != 0) begin
      fails++;
      $display("FAIL pn_fall: got %0d pulses, required 0", n_pn);
    end
  endtask

  task automatic test_reset_mid();
    push_seq();
    watch(9, 0, -1, -1, -1, -1);
    @(negedge clk_sys);
    scalerst = 1'b0;
    #1;
    tests++;
    if ({scaledatain, scalechoice, scaleload, scalstart, busy, done} !== '0) begin
      fails++;
      $display("FAIL reset_mid: got data=%h choice=%0d load=%b busy=%b, required all 0",
               scaledatain, scalechoice, scaleload, busy);
    end
    @(negedge clk_sys);
    scalerst = 1'b1;
    sb.delete();
    for (int k = 0; k < 32; k++) tbl[k] = '0;
    push_seq();
    watch(25, 0, -1, -1, -1, -1);
    tests++;
    if (n_strobe != 3 || sb.size() != 0 || n_done != 1) begin
      fails++;
      $display("FAIL reset_mid_reload: got strobes=%0d left=%0d done=%0d, required 3 0 1",
               n_strobe, sb.size(), n_done);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) tbl[k] = '0;
    test_reset();
    test_load_auto();
    test_load_noauto();
    test_abort();
    test_back_to_back();
    test_pn_change();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
